// File: rtl/hazard_scoreboard.sv
// Register scoreboard for long-latency writes: stalls decode on RAW/WAW/capacity hazards
// and flags stalls that run too long. Optional same-cycle writeback bypass: HZ_WB_BYPASS_EN.
module hazard_scoreboard #(
    parameter int NUM_REGS    = 32,
    parameter int IDX_W       = $clog2(NUM_REGS),
    parameter int MAX_PENDING = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [IDX_W-1:0]    id_rs1_idx,
    input  logic                id_rs1_used,
    input  logic [IDX_W-1:0]    id_rs2_idx,
    input  logic                id_rs2_used,
    input  logic [IDX_W-1:0]    id_rd_idx,
    input  logic                id_rd_we,
    input  logic                id_long,
    input  logic                flush,
    input  logic                wb_valid,
    input  logic [IDX_W-1:0]    wb_rd_idx,
    output logic                stall,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic [3:0]          outstanding,
    output logic                full,
    output logic                deadlock,
    output logic                err_wb,
    output logic                stall_state
);

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_STALLING = 1'b1
    } stall_state_t;

    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
    localparam logic [3:0]  MAX_C     = 4'(MAX_PENDING);

    stall_state_t        state_q, state_d;
    logic [15:0]         stall_cnt_q, stall_cnt_d;
    logic [NUM_REGS-1:0] mask_q, mask_d, pend_view, wb_onehot;
    logic [3:0]          cnt_q, cnt_d;
    logic                full_q, cap_block;
    logic                raw1, raw2, waw, cap;
    logic                issue, wb_hit, wb_err, dl_set;

    assign wb_onehot = wb_valid ? (NUM_REGS'(1) << wb_rd_idx) : '0;

`ifdef HZ_WB_BYPASS_EN
    // A writeback landing this cycle already resolves the hazard (register file writes through).
    assign pend_view = mask_q & ~wb_onehot;
    assign cap_block = (cnt_q - {3'b000, (wb_valid && cnt_q != 4'd0)}) >= MAX_C;
`else
    assign pend_view = mask_q;
    assign cap_block = full_q;
`endif

    assign raw1  = id_rs1_used && (id_rs1_idx != '0) && pend_view[id_rs1_idx];
    assign raw2  = id_rs2_used && (id_rs2_idx != '0) && pend_view[id_rs2_idx];
    assign waw   = id_rd_we && (id_rd_idx != '0) && pend_view[id_rd_idx];
    assign cap   = id_long && id_rd_we && cap_block;
    assign stall = id_valid && !flush && (raw1 || raw2 || waw || cap);

    assign issue  = id_valid && !flush && !stall && id_long && id_rd_we && (id_rd_idx != '0);
    assign wb_hit = wb_valid && (wb_rd_idx != '0) && mask_q[wb_rd_idx] && (cnt_q != 4'd0);
    assign wb_err = wb_valid && !wb_hit;

    always_comb begin
        mask_d = mask_q;
        cnt_d  = cnt_q;
        if (wb_hit) mask_d = mask_d & ~wb_onehot;
        // Set after clear so a same-index issue keeps the bit.
        if (issue) mask_d = mask_d | (NUM_REGS'(1) << id_rd_idx);
        case ({issue, wb_hit})
            2'b10:   cnt_d = cnt_q + 4'd1;
            2'b01:   cnt_d = cnt_q - 4'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (stall) begin
                    state_d     = S_STALLING;
                    stall_cnt_d = 16'd1;
                end
            end
            S_STALLING: begin
                if (stall) begin
                    stall_cnt_d = (stall_cnt_q >= TIMEOUT_C) ? TIMEOUT_C : stall_cnt_q + 16'd1;
                end else begin
                    state_d     = S_IDLE;
                    stall_cnt_d = 16'd0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                stall_cnt_d = 16'd0;
            end
        endcase
        dl_set = stall && (stall_cnt_d == TIMEOUT_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q      <= '0;
            cnt_q       <= 4'd0;
            full_q      <= 1'b0;
            err_wb      <= 1'b0;
            deadlock    <= 1'b0;
            state_q     <= S_IDLE;
            stall_cnt_q <= 16'd0;
        end else begin
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            full_q      <= (cnt_d == MAX_C);
            err_wb      <= err_wb | wb_err;
            deadlock    <= deadlock | dl_set;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pending_mask = mask_q;
    assign outstanding  = cnt_q;
    assign full         = full_q;
    assign stall_state  = state_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed testbench for hazard_scoreboard (MAX_PENDING=4, TIMEOUT=8).
module tb_hazard_scoreboard;

    localparam int NUM_REGS = 32;
    localparam int IDX_W    = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_long, flush, wb_valid;
    logic [IDX_W-1:0]    id_rs1_idx, id_rs2_idx, id_rd_idx, wb_rd_idx;
    logic                stall, full, deadlock, err_wb, stall_state;
    logic [NUM_REGS-1:0] pending_mask;
    logic [3:0]          outstanding;

    int tests  = 0;
    int failed = 0;

    hazard_scoreboard #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .MAX_PENDING(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1_idx(id_rs1_idx), .id_rs1_used(id_rs1_used),
        .id_rs2_idx(id_rs2_idx), .id_rs2_used(id_rs2_used),
        .id_rd_idx(id_rd_idx), .id_rd_we(id_rd_we), .id_long(id_long),
        .flush(flush), .wb_valid(wb_valid), .wb_rd_idx(wb_rd_idx),
        .stall(stall), .pending_mask(pending_mask), .outstanding(outstanding),
        .full(full), .deadlock(deadlock), .err_wb(err_wb), .stall_state(stall_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic rs1u,
                          input logic [4:0] rs2, input logic rs2u,
                          input logic [4:0] rd, input logic we, input logic lng);
        id_valid = v; id_rs1_idx = rs1; id_rs1_used = rs1u;
        id_rs2_idx = rs2; id_rs2_used = rs2u;
        id_rd_idx = rd; id_rd_we = we; id_long = lng;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] idx);
        wb_valid = v; wb_rd_idx = idx;
    endtask

    task automatic idle_inputs();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0);
        flush = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        tests++;
        if (pending_mask !== '0 || outstanding !== 4'd0 || full !== 1'b0 ||
            deadlock !== 1'b0 || err_wb !== 1'b0 || stall !== 1'b0 || stall_state !== 1'b0) begin
            failed++;
            $display("FAIL reset: mask=%h out=%0d full=%b dl=%b err=%b stall=%b st=%b expected all zero",
                     pending_mask, outstanding, full, deadlock, err_wb, stall, stall_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_raw();
        set_id(1, 0, 0, 0, 0, 5, 1, 1);
        #1;
        tests++;
        if (stall !== 1'b0) begin failed++; $display("FAIL raw_issue_stall: got %b expected 0", stall); end
        tick();
        set_id(1, 5, 1, 0, 0, 6, 1, 0);
        #1;
        tests++;
        if (stall !== 1'b1 || pending_mask !== 32'h0000_0020 || outstanding !== 4'd1) begin
            failed++;
            $display("FAIL raw_stall: stall=%b mask=%h out=%0d expected 1 00000020 1", stall, pending_mask, outstanding);
        end
        tick();
        set_wb(1, 5);
        #1;
        tests++;
`ifdef HZ_WB_BYPASS_EN
        if (stall !== 1'b0) begin failed++; $display("FAIL raw_wb_cycle: stall=%b expected 0", stall); end
`else
        if (stall !== 1'b1) begin failed++; $display("FAIL raw_wb_cycle: stall=%b expected 1", stall); end
`endif
        tick();
        set_wb(0, 0);
        #1;
        tests++;
        if (stall !== 1'b0 || pending_mask !== '0 || outstanding !== 4'd0 || err_wb !== 1'b0) begin
            failed++;
            $display("FAIL raw_after_wb: stall=%b mask=%h out=%0d err=%b expected 0 0 0 0",
                     stall, pending_mask, outstanding, err_wb);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_x0();
        set_id(1, 0, 1, 0, 1, 0, 1, 1);
        #1;
        tests++;
        if (stall !== 1'b0) begin failed++; $display("FAIL x0_stall: got %b expected 0", stall); end
        tick();
        idle_inputs();
        #1;
        tests++;
        if (pending_mask !== '0 || outstanding !== 4'd0) begin
            failed++;
            $display("FAIL x0_state: mask=%h out=%0d expected 0 0", pending_mask, outstanding);
        end
    endtask

    task automatic test_cap();
        for (int i = 1; i <= 4; i++) begin
            set_id(1, 0, 0, 0, 0, 5'(i), 1, 1);
            tick();
        end
        set_id(1, 0, 0, 0, 0, 11, 1, 0);
        #1;
        tests++;
        if (outstanding !== 4'd4 || full !== 1'b1 || stall !== 1'b0) begin
            failed++;
            $display("FAIL cap_full: out=%0d full=%b short_stall=%b expected 4 1 0", outstanding, full, stall);
        end
        set_id(1, 0, 0, 0, 0, 10, 1, 1);
        #1;
        tests++;
        if (stall !== 1'b1) begin failed++; $display("FAIL cap_stall: got %b expected 1", stall); end
        tick();
        set_wb(1, 1);
        #1;
`ifdef HZ_WB_BYPASS_EN
        tests++;
        if (stall !== 1'b0) begin failed++; $display("FAIL cap_wb_cycle: stall=%b expected 0", stall); end
        tick();
        set_wb(0, 0);
        idle_inputs();
`else
        tests++;
        if (stall !== 1'b1) begin failed++; $display("FAIL cap_wb_cycle: stall=%b expected 1", stall); end
        tick();
        set_wb(0, 0);
        #1;
        tests++;
        if (outstanding !== 4'd3 || full !== 1'b0 || stall !== 1'b0) begin
            failed++;
            $display("FAIL cap_release: out=%0d full=%b stall=%b expected 3 0 0", outstanding, full, stall);
        end
        tick();
        idle_inputs();
`endif
        #1;
        tests++;
        if (pending_mask !== 32'h0000_041C || outstanding !== 4'd4 || full !== 1'b1) begin
            failed++;
            $display("FAIL cap_fifth_issued: mask=%h out=%0d full=%b expected 0000041c 4 1",
                     pending_mask, outstanding, full);
        end
        set_wb(1, 2); tick();
        set_wb(1, 3); tick();
        set_wb(1, 4); tick();
        set_wb(1, 10); tick();
        set_wb(0, 0);
        #1;
        tests++;
        if (pending_mask !== '0 || outstanding !== 4'd0 || full !== 1'b0 || err_wb !== 1'b0) begin
            failed++;
            $display("FAIL cap_drain: mask=%h out=%0d full=%b err=%b expected 0 0 0 0",
                     pending_mask, outstanding, full, err_wb);
        end
    endtask

    task automatic test_same_cycle();
        set_id(1, 0, 0, 0, 0, 12, 1, 1);
        tick();
        set_id(1, 0, 0, 0, 0, 7, 1, 1);
        set_wb(1, 12);
        #1;
        tests++;
        if (stall !== 1'b0) begin failed++; $display("FAIL same_cycle_stall: got %b expected 0", stall); end
        tick();
        idle_inputs();
        #1;
        tests++;
        if (pending_mask !== 32'h0000_0080 || outstanding !== 4'd1) begin
            failed++;
            $display("FAIL same_cycle_diff: mask=%h out=%0d expected 00000080 1", pending_mask, outstanding);
        end
`ifdef HZ_WB_BYPASS_EN
        set_id(1, 0, 0, 0, 0, 7, 1, 1);
        set_wb(1, 7);
        tick();
        idle_inputs();
        #1;
        tests++;
        if (pending_mask !== 32'h0000_0080 || outstanding !== 4'd1) begin
            failed++;
            $display("FAIL same_cycle_same: mask=%h out=%0d expected 00000080 1", pending_mask, outstanding);
        end
`endif
        set_wb(1, 7);
        tick();
        set_wb(0, 0);
        #1;
        tests++;
        if (pending_mask !== '0 || outstanding !== 4'd0 || err_wb !== 1'b0) begin
            failed++;
            $display("FAIL same_cycle_drain: mask=%h out=%0d err=%b expected 0 0 0", pending_mask, outstanding, err_wb);
        end
    endtask

    task automatic test_err_reset();
        set_wb(1, 9);
        tick();
        set_wb(0, 0);
        tick();
        tests++;
        if (err_wb !== 1'b1 || outstanding !== 4'd0) begin
            failed++;
            $display("FAIL err_sticky: err=%b out=%0d expected 1 0", err_wb, outstanding);
        end
        set_id(1, 0, 0, 0, 0, 3, 1, 1);
        tick();
        idle_inputs();
        #1;
        tests++;
        if (outstanding !== 4'd1 || pending_mask !== 32'h0000_0008) begin
            failed++;
            $display("FAIL err_issue: out=%0d mask=%h expected 1 00000008", outstanding, pending_mask);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (pending_mask !== '0 || outstanding !== 4'd0 || full !== 1'b0 ||
            err_wb !== 1'b0 || deadlock !== 1'b0 || stall !== 1'b0) begin
            failed++;
            $display("FAIL async_reset: mask=%h out=%0d full=%b err=%b dl=%b stall=%b expected all zero",
                     pending_mask, outstanding, full, err_wb, deadlock, stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_wb(1, 3);
        tick();
        set_wb(0, 0);
        #1;
        tests++;
        if (err_wb !== 1'b1 || outstanding !== 4'd0) begin
            failed++;
            $display("FAIL wb_after_reset: err=%b out=%0d expected 1 0", err_wb, outstanding);
        end
    endtask

    task automatic test_deadlock();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        set_id(1, 0, 0, 0, 0, 8, 1, 1);
        tick();
        set_id(1, 0, 0, 8, 1, 9, 1, 0);
        #1;
        for (int k = 1; k <= 7; k++) tick();
        tests++;
        if (stall !== 1'b1 || stall_state !== 1'b1 || deadlock !== 1'b0) begin
            failed++;
            $display("FAIL deadlock_early: stall=%b st=%b dl=%b expected 1 1 0", stall, stall_state, deadlock);
        end
        tick();
        tests++;
        if (deadlock !== 1'b1) begin failed++; $display("FAIL deadlock_set: got %b expected 1", deadlock); end
        flush = 1'b1;
        #1;
        tests++;
        if (stall !== 1'b0) begin failed++; $display("FAIL flush_stall: got %b expected 0", stall); end
        tick();
        tests++;
        if (stall_state !== 1'b0 || deadlock !== 1'b1 || pending_mask !== 32'h0000_0100) begin
            failed++;
            $display("FAIL flush_idle: st=%b dl=%b mask=%h expected 0 1 00000100", stall_state, deadlock, pending_mask);
        end
        flush = 1'b0;
        #1;
        tests++;
        if (stall !== 1'b1) begin failed++; $display("FAIL stall_resume: got %b expected 1", stall); end
        set_wb(1, 8);
        tick();
        idle_inputs();
        tick();
        tests++;
        if (deadlock !== 1'b1 || outstanding !== 4'd0 || stall_state !== 1'b0 || err_wb !== 1'b0) begin
            failed++;
            $display("FAIL deadlock_end: dl=%b out=%0d st=%b err=%b expected 1 0 0 0",
                     deadlock, outstanding, stall_state, err_wb);
        end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_x0();
        test_cap();
        test_same_cycle();
        test_err_reset();
        test_deadlock();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
